// File: rtl/mux_n_to_1_reg.sv
// Registered N-to-1 channel multiplexer with direct-select and auto-scan modes.
// One-entry output buffer with a valid/ready handshake toward downstream.
module mux_n_to_1_reg #(
  parameter int N = 8,
  parameter int W = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  I,
  input  logic [SW-1:0]   S,
  input  logic            mode,
  input  logic            en,
  input  logic            ready,
  output logic [W-1:0]    Y,
  output logic [SW-1:0]   ch,
  output logic            valid
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [W-1:0]  r_y;
  logic [SW-1:0] r_ch;
  logic [SW-1:0] r_cnt;
  logic          w_valid;
  logic          w_cap;
  logic [SW-1:0] w_sel;
  logic [W-1:0]  w_chan [N];

  // Unpack the flat channel bus into one entry per channel.
  for (genvar k = 0; k < N; k++) begin : g_chan
    assign w_chan[k] = I[k*W +: W];
  end

  assign w_valid = (r_state == ST_FULL);
  assign w_cap   = en & (~w_valid | ready);
  assign w_sel   = mode ? r_cnt : S;

  // Next-state logic for the one-entry buffer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (en) w_state_nxt = ST_FULL;
      ST_FULL:  if (ready & ~en) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // State, sample and scan counter; N is a power of 2 so cnt wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_y     <= '0;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_y  <= w_chan[w_sel];
        r_ch <= w_sel;
        if (mode) r_cnt <= r_cnt + SW'(1);
      end
    end
  end

  assign Y     = r_y;
  assign ch    = r_ch;
  assign valid = w_valid;

endmodule

// File: doc/mux_n_to_1_reg.md
MUX_N_TO_1_REG -- requirements
Module: mux_n_to_1_reg

Interface
REQ-001 Parameter N, default 8: number of input channels; SHALL be a power of 2 in the range 2..64.
REQ-002 Parameter W, default 1: data width per channel, in bits; SHALL be at least 1.
REQ-003 Derived SW = $clog2(N): width of the select and channel fields.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 I  input  N*W  packed channel data; channel k SHALL occupy bits I[k*W +: W].
REQ-007 S  input  SW  channel select, used in mode 0 only.
REQ-008 mode  input  1  0 = direct select; 1 = auto-scan.
REQ-009 en  input  1  capture request.
REQ-010 ready  input  1  downstream accepts Y this cycle.
REQ-011 Y  output  W  registered selected data.
REQ-012 ch  output  SW  channel index that produced the current Y.
REQ-013 valid  output  1  Y/ch hold an unconsumed sample.

Function
REQ-014 Capture condition: cap = en & (~valid | ready), evaluated each cycle.
REQ-015 Active channel: sel_k = S when mode=0; sel_k = internal scan counter cnt (SW bits) when mode=1.
REQ-016 On cap, at the next edge: Y <= I[sel_k*W +: W]; ch <= sel_k; valid <= 1.
REQ-017 Latency SHALL be exactly 1 cycle from a capturing edge to Y, ch and valid becoming visible; there SHALL be no combinational path from I, S or mode to Y.
REQ-018 cnt SHALL increment only when cap=1 and mode=1.
REQ-019 cnt SHALL wrap from N-1 to 0.
REQ-020 cnt SHALL hold its value in mode 0.
REQ-021 cnt SHALL hold its value across mode changes; a return to mode 1 SHALL resume from the held value.
REQ-022 When cap=0, valid=1 and ready=1: valid SHALL go to 0 at the next edge, and Y and ch SHALL hold their values.
REQ-023 When cap=0 and (valid=0 or ready=0): Y, ch, valid and cnt SHALL all hold.
REQ-024 Simultaneous consume and capture (valid=1, ready=1, en=1): the new sample SHALL replace the old one, valid SHALL stay 1, and one transfer per cycle SHALL be sustained.
REQ-025 A mode or S change while valid=1 and ready=0 SHALL have no effect until the next capture.
REQ-026 Data changes on I while valid=1 SHALL NOT alter Y; Y is sampled only on cap.
REQ-027 The state machine SHALL have two states, EMPTY (valid=0) and FULL (valid=1):
- EMPTY -> FULL on en.
- FULL -> EMPTY on ready & ~en.
- FULL -> FULL on ~ready, or on ready & en.

Reset
REQ-028 While rst=1 at an edge: Y=0, ch=0, valid=0, cnt=0.
REQ-029 rst SHALL have priority over en, ready and mode at the same edge.
REQ-030 A reset mid-scan SHALL restart scanning from channel 0.
REQ-031 The first capture SHALL be possible on the first edge after rst deasserts.

Verification
REQ-032 N=8, W=1, I=8'b10011100, mode=0, ready=1, en=1, S stepped 0..7 one per cycle -> Y sequence 0,0,1,1,1,0,0,1, each appearing one cycle after its S, with ch equal to the S of the previous cycle.
REQ-033 Same I, mode=1, en=1, ready=1 for 10 cycles -> ch = 0,1,...,7,0,1 (wrap after 7); Y follows I[ch].
REQ-034 Backpressure: mode=1, capture ch=2, then ready=0 for 3 cycles with en=1 -> Y, ch=2 and valid=1 hold; cnt stays 3; after ready=1 the next capture yields ch=3.
REQ-035 Reset mid-scan: rst=1 for one cycle at ch=5 -> Y=0, ch=0, valid=0; the next capture yields ch=0.
REQ-036 N=4, W=4, I=16'hA5C3, mode=0, S=2 then S=3 -> Y=4'h5 then 4'hA; en=0 with ready=1 -> valid drops to 0 after one cycle and Y holds 4'hA.
